// File: rtl/wrr_pkg.sv
// Shared constants, ID type and grant-vector helpers for the WRR arbiter and its dispatch stage.
package wrr_pkg;

    localparam int N       = 32;
    localparam int ID_BITS = $clog2(N);

    typedef logic [ID_BITS-1:0] wrr_id_t;

    function automatic bit onehot_chk(logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

endpackage

// File: rtl/wrr_grant_dispatch_if.sv
// Grant channel from the arbiter plus the valid/ready dispatch channel to the shared resource.
interface wrr_grant_dispatch_if;
    import wrr_pkg::*;

    logic [N-1:0] gnt_w;
    wrr_id_t      gnt_id;
    logic         ack;
    logic         out_valid;
    wrr_id_t      out_id;
    logic         out_ready;

    // master: arbiter + downstream consumer; slave: the dispatch block
    modport master (
        output gnt_w, gnt_id, out_ready,
        input  ack, out_valid, out_id
    );

    modport slave (
        input  gnt_w, gnt_id, out_ready,
        output ack, out_valid, out_id
    );

endinterface

// File: rtl/wrr_id_fifo.sv
// In-order ID queue with a registered head; push-to-head latency 1, no bypass.
// Push is dropped when full and pop is ignored when empty; head holds its last value when empty.
module wrr_id_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 5,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_nxt  = do_pop ? rd_ptr + PW'(1) : rd_ptr;

    always_comb begin
        cnt_nxt = count;
        case ({do_push, do_pop})
            2'b10:   cnt_nxt = count + CW'(1);
            2'b01:   cnt_nxt = count - CW'(1);
            default: cnt_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
            // Head reloads only when it changes; a just-pushed entry at the new head is not yet in mem.
            if ((cnt_nxt != '0) && (do_pop || empty)) begin
                head <= (do_push && (rd_nxt == wr_ptr)) ? push_data : mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/wrr_grant_dispatch.sv
// Accepts well-formed one-hot grants into an in-order queue (ack combinational, head latency 1).
// ack drops only when the queue is full or the grant is malformed; out_ready never reaches ack.
module wrr_grant_dispatch
    import wrr_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int CNT_W = 16,
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    wrr_grant_dispatch_if.slave bus,
    output logic [OCC_W-1:0]   occupancy,
    output logic               err_grant,
    output logic [CNT_W-1:0]   grant_cnt
);

    logic    gnt_ok;
    logic    gnt_any;
    logic    full;
    logic    empty;
    logic    ack_i;
    logic    pop;
    wrr_id_t head;

    assign gnt_any = (bus.gnt_w != '0);
    assign gnt_ok  = gnt_any && onehot_chk(bus.gnt_w) && bus.gnt_w[bus.gnt_id];
    assign ack_i   = gnt_ok && !full;
    assign pop     = !empty && bus.out_ready;

    assign bus.ack       = ack_i;
    assign bus.out_valid = !empty;
    assign bus.out_id    = head;

    wrr_id_fifo #(
        .DEPTH (DEPTH),
        .W     (ID_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ack_i),
        .push_data (bus.gnt_id),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_grant <= 1'b0;
            grant_cnt <= '0;
        end else begin
            if (gnt_any && !gnt_ok) begin
                err_grant <= 1'b1;
            end
            if (ack_i && (grant_cnt != '1)) begin
                grant_cnt <= grant_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wrr_grant_dispatch.sv
// Directed vector bench for wrr_grant_dispatch; state outputs and ack checked just after the falling edge.
module tb_wrr_grant_dispatch;
    import wrr_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       occupancy;
    logic             err_grant;
    logic [CNT_W-1:0] grant_cnt;

    int checks = 0;
    int errors = 0;

    wrr_grant_dispatch_if bus ();

    wrr_grant_dispatch #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .occupancy (occupancy),
        .err_grant (err_grant),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] gw;
        logic [4:0]  gid;
        logic        rdy;
        logic        ack;
        logic        vld;
        logic [4:0]  oid;
        logic [2:0]  occ;
        logic        err;
        logic [4:0]  cnt;
    } vec_t;

    vec_t vt [29];

    function automatic logic [31:0] g(int i);
        logic [31:0] one = 32'd1;
        return one << i;
    endfunction

    function automatic vec_t mk(logic [31:0] gw, int gid, bit rdy, bit ack, bit vld,
                                int oid, int occ, bit err, int cnt);
        vec_t v;
        v.gw  = gw;
        v.gid = 5'(gid);
        v.rdy = rdy;
        v.ack = ack;
        v.vld = vld;
        v.oid = 5'(oid);
        v.occ = 3'(occ);
        v.err = err;
        v.cnt = 5'(cnt);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic [31:0] gw, int gid, bit rdy);
        bus.gnt_w     = gw;
        bus.gnt_id    = 5'(gid);
        bus.out_ready = rdy;
    endtask

    initial begin
        // rows: inputs, then expected ack (this cycle) and state outputs (before this edge)
        vt[0]  = mk(32'h0,   0, 0, 0, 0,  0, 0, 0,  0);
        vt[1]  = mk(g(5),    5, 1, 1, 0,  0, 0, 0,  0);
        vt[2]  = mk(32'h0,   0, 1, 0, 1,  5, 1, 0,  1);
        vt[3]  = mk(32'h0,  17, 0, 0, 0,  5, 0, 0,  1);
        vt[4]  = mk(g(1),    1, 0, 1, 0,  5, 0, 0,  1);
        vt[5]  = mk(g(2),    2, 0, 1, 1,  1, 1, 0,  2);
        vt[6]  = mk(g(3),    3, 0, 1, 1,  1, 2, 0,  3);
        vt[7]  = mk(g(4),    4, 0, 1, 1,  1, 3, 0,  4);
        vt[8]  = mk(g(7),    7, 0, 0, 1,  1, 4, 0,  5);
        vt[9]  = mk(g(7),    7, 1, 0, 1,  1, 4, 0,  5);
        vt[10] = mk(g(7),    7, 0, 1, 1,  2, 3, 0,  5);
        vt[11] = mk(32'h0,   0, 1, 0, 1,  2, 4, 0,  6);
        vt[12] = mk(32'h0,   0, 1, 0, 1,  3, 3, 0,  6);
        vt[13] = mk(32'h0,   0, 1, 0, 1,  4, 2, 0,  6);
        vt[14] = mk(32'h0,   0, 1, 0, 1,  7, 1, 0,  6);
        vt[15] = mk(32'h0,   0, 0, 0, 0,  7, 0, 0,  6);
        vt[16] = mk(g(3),    3, 0, 1, 0,  7, 0, 0,  6);
        vt[17] = mk(g(9),    9, 0, 1, 1,  3, 1, 0,  7);
        vt[18] = mk(g(12),  12, 1, 1, 1,  3, 2, 0,  8);
        vt[19] = mk(32'h0,   0, 1, 0, 1,  9, 2, 0,  9);
        vt[20] = mk(32'h0,   0, 1, 0, 1, 12, 1, 0,  9);
        vt[21] = mk(32'h0,   0, 0, 0, 0, 12, 0, 0,  9);
        vt[22] = mk(g(20),  20, 0, 1, 0, 12, 0, 0,  9);
        vt[23] = mk(32'h6,   1, 0, 0, 1, 20, 1, 0, 10);
        vt[24] = mk(32'h0,   0, 0, 0, 1, 20, 1, 1, 10);
        vt[25] = mk(32'h10,  2, 0, 0, 1, 20, 1, 1, 10);
        vt[26] = mk(32'h0,   0, 0, 0, 1, 20, 1, 1, 10);
        vt[27] = mk(32'h0,   0, 1, 0, 1, 20, 1, 1, 10);
        vt[28] = mk(32'h0,   0, 0, 0, 0, 20, 0, 1, 10);

        rst = 1'b1;
        drive(32'h0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            drive(vt[i].gw, int'(vt[i].gid), vt[i].rdy);
            #1;
            chk($sformatf("v%0d.ack", i), 32'(bus.ack), 32'(vt[i].ack));
            chk($sformatf("v%0d.out_valid", i), 32'(bus.out_valid), 32'(vt[i].vld));
            if (vt[i].vld || i < 4)
                chk($sformatf("v%0d.out_id", i), 32'(bus.out_id), 32'(vt[i].oid));
            chk($sformatf("v%0d.occupancy", i), 32'(occupancy), 32'(vt[i].occ));
            chk($sformatf("v%0d.err_grant", i), 32'(err_grant), 32'(vt[i].err));
            chk($sformatf("v%0d.grant_cnt", i), 32'(grant_cnt), 32'(vt[i].cnt));
            @(negedge clk);
        end

        // nine push/pop pairs stream IDs 21..29 through the pointer wrap
        for (int k = 0; k < 11; k++) begin
            if (k < 9) drive(g(21 + k), 21 + k, 1);
            else       drive(32'h0, 0, 1);
            #1;
            if (k < 9) chk($sformatf("wrap%0d.ack", k), 32'(bus.ack), 32'd1);
            chk($sformatf("wrap%0d.out_valid", k), 32'(bus.out_valid), (k == 0 || k == 10) ? 32'd0 : 32'd1);
            if (k > 0) chk($sformatf("wrap%0d.out_id", k), 32'(bus.out_id), 32'(20 + ((k > 9) ? 9 : k)));
            chk($sformatf("wrap%0d.occupancy", k), 32'(occupancy), (k == 0 || k == 10) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        chk("wrap.grant_cnt", 32'(grant_cnt), 32'd19);

        // reset with three entries queued and a grant pending drops everything
        for (int k = 1; k <= 3; k++) begin
            drive(g(k), k, 0);
            @(negedge clk);
        end
        drive(32'h0, 0, 0);
        #1;
        chk("prerst.occupancy", 32'(occupancy), 32'd3);
        chk("prerst.out_id", 32'(bus.out_id), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        drive(g(4), 4, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h0, 0, 0);
        #1;
        chk("rst.occupancy", 32'(occupancy), 32'd0);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.out_id", 32'(bus.out_id), 32'd0);
        chk("rst.err_grant", 32'(err_grant), 32'd0);
        chk("rst.grant_cnt", 32'(grant_cnt), 32'd0);
        @(negedge clk);

        // saturate the 5-bit grant counter, then confirm it holds
        for (int k = 0; k < 31; k++) begin
            drive(g(k), k, 1);
            @(negedge clk);
        end
        drive(32'h0, 0, 1);
        #1;
        chk("sat.grant_cnt_max", 32'(grant_cnt), 32'd31);
        @(negedge clk);
        drive(g(31), 31, 1);
        #1;
        chk("sat.ack", 32'(bus.ack), 32'd1);
        @(negedge clk);
        drive(32'h0, 0, 1);
        #1;
        chk("sat.grant_cnt_hold", 32'(grant_cnt), 32'd31);
        chk("sat.out_id", 32'(bus.out_id), 32'd31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
